// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_pkg
//  Description : Shared types and helpers for the VGA raster timing generator.
//                Holds the standard VESA mode constant sets (640x480@60,
//                800x600@60, 1024x768@60) and the line/frame total helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_gen_pkg;

    typedef enum logic [1:0] {
        MODE_640X480  = 2'd0,
        MODE_800X600  = 2'd1,
        MODE_1024X768 = 2'd2
    } mode_e;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        bit          h_pol;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        bit          v_pol;
    } mode_t;

    // Standard timing sets; 640x480 is the 25.175 MHz default, 800x600 runs
    // from 40 MHz with positive syncs, 1024x768 from 65 MHz with negative syncs.
    function automatic mode_t mode_timing(input mode_e mode);
        mode_t m;
        case (mode)
            MODE_800X600:  m = '{800, 40, 128, 88, 1'b1, 600, 1, 4, 23, 1'b1};
            MODE_1024X768: m = '{1024, 24, 136, 160, 1'b0, 768, 3, 6, 29, 1'b0};
            default:       m = '{640, 16, 96, 48, 1'b0, 480, 10, 2, 33, 1'b0};
        endcase
        return m;
    endfunction

    function automatic int unsigned calc_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam mode_t c_default_mode = mode_timing(MODE_640X480);

endpackage : vga_timing_gen_pkg
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Raster timing bundle between the timing generator (master)
//                and the downstream pixel pipeline (slave).
//                en           : advance raster (1) / freeze everything (0)
//                vga_hs/vs    : syncs, vga_disp_en : active area
//                vga_pos_hor/ver : pixel x/y (0 outside active area)
//                line_start/frame_start/vblank_start : 1-cycle strobes
//                frame_cnt    : frames completed, wrapping
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int CW   = 10,
    parameter int FC_W = 8
) ();
    logic            en;
    logic            vga_hs;
    logic            vga_vs;
    logic            vga_disp_en;
    logic [CW-1:0]   vga_pos_hor;
    logic [CW-1:0]   vga_pos_ver;
    logic            line_start;
    logic            frame_start;
    logic            vblank_start;
    logic [FC_W-1:0] frame_cnt;

    modport master (
        input  en,
        output vga_hs, vga_vs, vga_disp_en, vga_pos_hor, vga_pos_ver,
               line_start, frame_start, vblank_start, frame_cnt
    );

    modport slave (
        output en,
        input  vga_hs, vga_vs, vga_disp_en, vga_pos_hor, vga_pos_ver,
               line_start, frame_start, vblank_start, frame_cnt
    );
endinterface : vga_timing_gen_if
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : vga_delay_line
//  Description : DEPTH-stage enabled shift register with asynchronous clear
//                to RST_VAL. DEPTH=0 is a pure passthrough.
//  Ports       : clk, rst_n (async, active-low), i_en (shift), i_d, o_q
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_passthru
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, i_en};
            assign o_q      = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule : vga_delay_line
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA/VESA raster timing generator. Free-running
//                h/v counters, registered decode (stage 0) and PIPE_DLY extra
//                register stages; outputs lag the counters by 1+PIPE_DLY
//                enabled cycles. en=0 freezes every register.
//  Ports       : clk_25      - pixel clock
//                sys_reset_n - asynchronous active-low reset
//                vif         - timing bundle (master modport)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int CW       = 10,
    parameter int H_ACTIVE = int'(c_default_mode.h_active),
    parameter int H_FP     = int'(c_default_mode.h_fp),
    parameter int H_SYNC   = int'(c_default_mode.h_sync),
    parameter int H_BP     = int'(c_default_mode.h_bp),
    parameter bit H_POL    = c_default_mode.h_pol,
    parameter int V_ACTIVE = int'(c_default_mode.v_active),
    parameter int V_FP     = int'(c_default_mode.v_fp),
    parameter int V_SYNC   = int'(c_default_mode.v_sync),
    parameter int V_BP     = int'(c_default_mode.v_bp),
    parameter bit V_POL    = c_default_mode.v_pol,
    parameter int PIPE_DLY = 0,
    parameter int FC_W     = 8
) (
    input  wire logic        clk_25,
    input  wire logic        sys_reset_n,
    vga_timing_gen_if.master vif
);

    localparam int unsigned c_h_total_i = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned c_v_total_i = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // All compares are done one bit wider than the counters so that a total
    // of exactly 2**CW does not truncate.
    localparam logic [CW:0] c_h_last     = (CW+1)'(c_h_total_i - 1);
    localparam logic [CW:0] c_v_last     = (CW+1)'(c_v_total_i - 1);
    localparam logic [CW:0] c_h_active   = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] c_v_active   = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] c_hs_start   = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] c_hs_end     = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] c_vs_start   = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] c_vs_end     = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    // Bundle layout, MSB first: hs, vs, de, x, y, line, frame, vblank, fcnt
    localparam int c_bw     = 6 + 2*CW + FC_W;
    localparam int c_pos_y  = FC_W + 3;
    localparam int c_pos_x  = c_pos_y + CW;
    localparam int c_pos_de = c_pos_x + CW;
    localparam logic [c_bw-1:0] c_rst_val = {~H_POL, ~V_POL, {(c_bw-2){1'b0}}};

    generate
        if (64'(c_h_total_i) > (64'd1 << CW) || 64'(c_v_total_i) > (64'd1 << CW) ||
            PIPE_DLY < 0 || PIPE_DLY > 7 ||
            H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
            V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_param_err
            $error("vga_timing_gen: illegal timing parameter set");
        end
    endgenerate

    logic [CW-1:0]   r_h_cnt;
    logic [CW-1:0]   r_v_cnt;
    logic [FC_W-1:0] r_frame_cnt;
    logic [c_bw-1:0] r_stage0;

    logic [CW:0]     w_h_ext;
    logic [CW:0]     w_v_ext;
    logic            w_h_last;
    logic            w_v_last;
    logic            w_de;
    logic [c_bw-1:0] w_stage0_d;
    logic [c_bw-1:0] w_out;

    assign w_h_ext  = {1'b0, r_h_cnt};
    assign w_v_ext  = {1'b0, r_v_cnt};
    assign w_h_last = (w_h_ext == c_h_last);
    assign w_v_last = (w_v_ext == c_v_last);

    // Frame counter advances together with the wrap to (0,0), so the decode
    // of h=0,v=0 carries the new count alongside frame_start.
    always_ff @(posedge clk_25 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_cnt <= '0;
        end else if (vif.en) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                if (w_v_last) begin
                    r_v_cnt     <= '0;
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end else begin
                    r_v_cnt <= r_v_cnt + 1'b1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_de       = (w_h_ext < c_h_active) && (w_v_ext < c_v_active);
        w_stage0_d = c_rst_val;
        w_stage0_d[c_bw-1]   = ((w_h_ext >= c_hs_start) && (w_h_ext < c_hs_end)) ? H_POL : ~H_POL;
        w_stage0_d[c_bw-2]   = ((w_v_ext >= c_vs_start) && (w_v_ext < c_vs_end)) ? V_POL : ~V_POL;
        w_stage0_d[c_pos_de] = w_de;
        w_stage0_d[c_pos_x +: CW] = w_de ? r_h_cnt : '0;
        w_stage0_d[c_pos_y +: CW] = w_de ? r_v_cnt : '0;
        w_stage0_d[FC_W+2]   = (r_h_cnt == '0);
        w_stage0_d[FC_W+1]   = (r_h_cnt == '0) && (r_v_cnt == '0);
        w_stage0_d[FC_W]     = (r_h_cnt == '0) && (w_v_ext == c_v_active);
        w_stage0_d[FC_W-1:0] = r_frame_cnt;
    end

    always_ff @(posedge clk_25 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_stage0 <= c_rst_val;
        end else if (vif.en) begin
            r_stage0 <= w_stage0_d;
        end
    end

    vga_delay_line #(
        .WIDTH   (c_bw),
        .DEPTH   (PIPE_DLY),
        .RST_VAL (c_rst_val)
    ) u_delay (
        .clk   (clk_25),
        .rst_n (sys_reset_n),
        .i_en  (vif.en),
        .i_d   (r_stage0),
        .o_q   (w_out)
    );

    assign vif.vga_hs       = w_out[c_bw-1];
    assign vif.vga_vs       = w_out[c_bw-2];
    assign vif.vga_disp_en  = w_out[c_pos_de];
    assign vif.vga_pos_hor  = w_out[c_pos_x +: CW];
    assign vif.vga_pos_ver  = w_out[c_pos_y +: CW];
    assign vif.line_start   = w_out[FC_W+2];
    assign vif.frame_start  = w_out[FC_W+1];
    assign vif.vblank_start = w_out[FC_W];
    assign vif.frame_cnt    = w_out[FC_W-1:0];

endmodule : vga_timing_gen
`default_nettype wire
